// File: rtl/atc_e_stage.sv
// D->E hazard-tracking pipeline stage with the mult/div busy countdown used for HI/LO stalls.
// Optional ATC_E_TNEW_EN adds the registered tnewE output (cycles until the E result is ready).
module atc_e_stage #(
  parameter int CNT_W       = 4,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             DEMWclr,
  input  logic             stall,
  input  logic [4:0]       ra1D,
  input  logic [4:0]       ra2D,
  input  logic [4:0]       waD,
  input  logic [2:0]       resD,
  input  logic             md_startD,
  input  logic             md_divD,
  output logic [4:0]       ra1E,
  output logic [4:0]       ra2E,
  output logic [4:0]       waE,
  output logic [2:0]       resE,
`ifdef ATC_E_TNEW_EN
  output logic [1:0]       tnewE,
`endif
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0] md_cnt_nxt;

  // A start is only honoured with the unit idle; a start while counting is ignored.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (md_startD && !stall && md_cnt == '0)
      md_cnt_nxt = md_divD ? DIV_LOAD : MULT_LOAD;
    else if (md_cnt != '0)
      md_cnt_nxt = md_cnt - 1'b1;
  end

  // NOTE: reset is synchronous and active-low, so it only takes effect on a clk edge;
  // the flush shares the same path because it must leave the stage in the identical state.
  always_ff @(posedge clk) begin
    if (!rst || DEMWclr) begin
      ra1E   <= '0;
      ra2E   <= '0;
      waE    <= '0;
      resE   <= '0;
      md_cnt <= '0;
    end else if (stall) begin
      // Bubble into E; the mult/div unit keeps running underneath.
      ra1E   <= '0;
      ra2E   <= '0;
      waE    <= '0;
      resE   <= '0;
      md_cnt <= md_cnt_nxt;
    end else begin
      ra1E   <= ra1D;
      ra2E   <= ra2D;
      waE    <= waD;
      resE   <= resD;
      md_cnt <= md_cnt_nxt;
    end
  end

  assign md_busy = (md_cnt != '0);

`ifdef ATC_E_TNEW_EN
  logic [1:0] tnew_d;

  always_comb begin
    tnew_d = 2'd0;
    unique case (resD)
      3'd1:    tnew_d = 2'd1;  // ALU
      3'd2:    tnew_d = 2'd2;  // DM
      3'd4:    tnew_d = 2'd1;  // MD
      default: tnew_d = 2'd0;  // NW, PC, reserved
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || DEMWclr || stall)
      tnewE <= 2'd0;
    else
      tnewE <= tnew_d;
  end
`endif

endmodule

// File: tb/tb_atc_e_stage.sv
// Scoreboard bench for atc_e_stage: directed vectors push hand-computed expectations,
// a monitor pops one per clock and compares after the edge.
module tb_atc_e_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       DEMWclr = 1'b0;
  logic       stall = 1'b0;
  logic [4:0] ra1D = '0, ra2D = '0, waD = '0;
  logic [2:0] resD = '0;
  logic       md_startD = 1'b0, md_divD = 1'b0;
  logic [4:0] ra1E, ra2E, waE;
  logic [2:0] resE;
  logic       md_busy;
  logic [3:0] md_cnt;
`ifdef ATC_E_TNEW_EN
  logic [1:0] tnewE;
`endif

  atc_e_stage #(.CNT_W(4), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .DEMWclr(DEMWclr), .stall(stall),
    .ra1D(ra1D), .ra2D(ra2D), .waD(waD), .resD(resD),
    .md_startD(md_startD), .md_divD(md_divD),
    .ra1E(ra1E), .ra2E(ra2E), .waE(waE), .resE(resE),
`ifdef ATC_E_TNEW_EN
    .tnewE(tnewE),
`endif
    .md_busy(md_busy), .md_cnt(md_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ra1, ra2, wa;
    logic [2:0] res;
    logic [3:0] cnt;
    logic       busy;
    logic [1:0] tnew;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Drive one D-side vector at the falling edge; expectation is for the outputs after the next rising edge.
  task automatic step(input string tag, input logic r, c, s,
                      input logic [4:0] a1, a2, w, input logic [2:0] rs,
                      input logic st, dv,
                      input logic [4:0] e1, e2, ew, input logic [2:0] er,
                      input logic [3:0] ec, input logic [1:0] et);
    exp_t e;
    @(negedge clk);
    rst = r; DEMWclr = c; stall = s;
    ra1D = a1; ra2D = a2; waD = w; resD = rs;
    md_startD = st; md_divD = dv;
    e.ra1 = e1; e.ra2 = e2; e.wa = ew; e.res = er;
    e.cnt = ec; e.busy = (ec != 4'd0); e.tnew = et; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic nop(input string tag, input logic [3:0] ec);
    step(tag, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b0,
         5'd0, 5'd0, 5'd0, 3'd0, ec, 2'd0);
  endtask

  // Monitor: one output presentation per clock, compared 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        logic bad;
        logic [1:0] act_tnew;
        e = exp_q.pop_front();
        vectors++;
`ifdef ATC_E_TNEW_EN
        act_tnew = tnewE;
`else
        act_tnew = e.tnew;
`endif
        bad = (ra1E !== e.ra1) || (ra2E !== e.ra2) || (waE !== e.wa) || (resE !== e.res) ||
              (md_cnt !== e.cnt) || (md_busy !== e.busy) || (act_tnew !== e.tnew);
        if (bad) begin
          miscompares++;
          $display("FAIL %s: got ra1=%0d ra2=%0d wa=%0d res=%0d cnt=%0d busy=%0b tnew=%0d, want ra1=%0d ra2=%0d wa=%0d res=%0d cnt=%0d busy=%0b tnew=%0d",
                   e.tag, ra1E, ra2E, waE, resE, md_cnt, md_busy, act_tnew,
                   e.ra1, e.ra2, e.wa, e.res, e.cnt, e.busy, e.tnew);
        end
      end
    end
  end

  initial begin
    // 1: reset with busy D inputs, then a normal capture
    step("rst0_a", 0, 0, 0, 9, 10, 11, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    step("rst0_b", 0, 1, 1, 9, 10, 11, 2, 1, 0,  0, 0, 0, 0, 0, 0);
    step("capture", 1, 0, 0, 3, 4, 5, 2, 0, 0,  3, 4, 5, 2, 0, 2);

    // 2: stall inserts a bubble, then the held instruction enters E
    step("stall_bubble", 1, 0, 1, 1, 2, 7, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    step("after_stall",  1, 0, 0, 1, 2, 7, 1, 0, 0,  1, 2, 7, 1, 0, 1);

    // 3: mult countdown 5..0, then div countdown 10..0 with saturation at 0
    step("mult_start", 1, 0, 0, 1, 2, 8, 4, 1, 0,  1, 2, 8, 4, 5, 1);
    for (int i = 4; i >= 0; i--) nop("mult_cnt", 4'(i));
    nop("mult_sat", 0);
    step("div_start", 1, 0, 0, 6, 0, 0, 4, 1, 1,  6, 0, 0, 4, 10, 1);
    for (int i = 9; i >= 0; i--) nop("div_cnt", 4'(i));

    // 4: clear and reset abandon an in-flight div at md_cnt=6
    step("div_start2", 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 10, 0);
    for (int i = 9; i >= 6; i--) nop("div_cnt2", 4'(i));
    step("clr_mid", 1, 1, 0, 8, 9, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    step("div_start3", 1, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 10, 0);
    for (int i = 9; i >= 6; i--) nop("div_cnt3", 4'(i));
    step("rst_mid", 0, 0, 0, 8, 9, 5, 1, 1, 0,  0, 0, 0, 0, 0, 0);

    // 5: start during stall ignored; start while counting ignored but D captured
    step("start_stalled", 1, 0, 1, 1, 1, 3, 1, 1, 1,  0, 0, 0, 0, 0, 0);
    nop("idle", 0);
    step("mult_start2", 1, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 5, 0);
    nop("mult_cnt2", 4);
    nop("mult_cnt2", 3);
    step("start_busy", 1, 0, 0, 6, 7, 12, 1, 1, 1,  6, 7, 12, 1, 2, 1);
    step("stall_counts", 1, 0, 1, 6, 7, 12, 1, 1, 0,  0, 0, 0, 0, 1, 0);
    nop("cnt_done", 0);

    // 6: result-source mapping incl. PC, NW and reserved pass-through
    step("res_pc",   1, 0, 0, 2, 3, 31, 3, 0, 0,  2, 3, 31, 3, 0, 0);
    step("res_rsv5", 1, 0, 0, 4, 5, 6,  5, 0, 0,  4, 5, 6,  5, 0, 0);
    step("res_rsv7", 1, 0, 0, 31, 31, 1, 7, 0, 0, 31, 31, 1, 7, 0, 0);
    step("res_dm",   1, 0, 0, 7, 8, 9,  2, 0, 0,  7, 8, 9,  2, 0, 2);
    step("res_nw",   1, 0, 0, 1, 0, 0,  0, 0, 0,  1, 0, 0,  0, 0, 0);

    // Drain: every pushed expectation must have been popped within a bounded wait
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
